// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch front end.
// Holds the fetch FSM states, the FIFO entry layout and PC helpers.
package instr_fetch_pkg;

    // Instruction word as handed to decode.
    typedef logic [31:0] instr_packet;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        instr_packet instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    // Sequential fetch step; wraps modulo 2^32.
    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Prefetch FIFO between memory responses and decode.
// The head entry is held in dedicated registers; flush beats push.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         head_valid,
    output fetch_entry_t head_data,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_n;
    logic [CW-1:0] count_n;
    logic          do_pop;
    logic          do_push;
    logic          head_valid_n;
    fetch_entry_t  head_data_n;

    assign do_pop  = pop & head_valid;
    assign do_push = push & ~flush;

    // Next occupancy and the entry that becomes the new head.
    always_comb begin
        rd_ptr_n     = do_pop ? rd_ptr + 1'b1 : rd_ptr;
        count_n      = count + CW'(do_push) - CW'(do_pop);
        head_valid_n = 1'b0;
        head_data_n  = head_data;
        if (flush) begin
            count_n      = '0;
            head_valid_n = 1'b0;
        end else if (count_n != '0) begin
            head_valid_n = 1'b1;
            // Nothing left in storage ahead of the push: it becomes head.
            if (count == CW'(do_pop)) begin
                head_data_n = push_data;
            end else begin
                head_data_n = mem[rd_ptr_n];
            end
        end
    end

    // Entry storage; only written, never cleared.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr_n;
            count      <= count_n;
            head_valid <= head_valid_n;
            head_data  <= head_data_n;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32 fetch front end: sequential requests, prefetch FIFO, redirects.
// Optional macro FETCH_STARVE_CNT_EN adds the starve_count output.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = FETCH_RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output instr_packet instr,
    output logic [31:0] instr_pc
`ifdef FETCH_STARVE_CNT_EN
    ,
    output logic [31:0] starve_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = CW + 1;

    fetch_state_t  state;
    fetch_state_t  state_n;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   target_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_n;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_cnt_n;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] occ_n;
    logic          redirect_take;
    logic          req_fire;
    logic          pop_fire;
    logic          rsp_push;
    logic          req_valid_n;
    fetch_entry_t  rsp_entry;
    fetch_entry_t  head_entry;

    assign redirect_take = redirect_valid & (state != IDLE);
    assign req_fire      = mem_req_valid & mem_req_ready;
    assign pop_fire      = instr_valid & instr_ready;
    assign target_pc     = word_align(redirect_pc);
    assign mem_req_addr  = fetch_pc;

    // Stale words and words racing a redirect never reach the FIFO.
    assign rsp_push = mem_rsp_valid & (drop_cnt == '0) & ~redirect_take;

    assign inflight_n = inflight + CW'(req_fire) - CW'(mem_rsp_valid);

    assign occ_n = redirect_take ? '0
                 : fifo_count + CW'(rsp_push) - CW'(pop_fire);

    assign rsp_entry.instr = mem_rsp_data;
    assign rsp_entry.pc    = rsp_pc;

    assign instr    = head_entry.instr;
    assign instr_pc = head_entry.pc;

    // Words still owed by memory that belong to the old path.
    always_comb begin
        drop_cnt_n = drop_cnt;
        if (redirect_take) begin
            drop_cnt_n = inflight_n;
        end else if (mem_rsp_valid && drop_cnt != '0) begin
            drop_cnt_n = drop_cnt - 1'b1;
        end
    end

    // Next FSM state; FLUSH lasts while stale words are owed.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:       state_n = RUN;
            RUN, FLUSH: state_n = (drop_cnt_n != '0) ? FLUSH : RUN;
            default:    state_n = IDLE;
        endcase
    end

    // Credit check: every issued request must have a FIFO slot.
    always_comb begin
        req_valid_n = 1'b0;
        if (state_n == RUN) begin
            req_valid_n = ((WW'(inflight_n) + WW'(occ_n)) < WW'(FIFO_DEPTH))
                        && (inflight_n < CW'(MAX_INFLIGHT));
        end
    end

    // FSM with registered request valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
        end else begin
            state         <= state_n;
            mem_req_valid <= req_valid_n;
        end
    end

    // Fetch/response PCs and outstanding-request bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_n;
            drop_cnt <= drop_cnt_n;
            if (redirect_take) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
            end else begin
                if (req_fire) begin
                    fetch_pc <= pc_step(fetch_pc);
                end
                if (rsp_push) begin
                    rsp_pc <= pc_step(rsp_pc);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_take),
        .push      (rsp_push),
        .push_data (rsp_entry),
        .pop       (instr_ready),
        .head_valid(instr_valid),
        .head_data (head_entry),
        .count     (fifo_count)
    );

`ifdef FETCH_STARVE_CNT_EN
    // Saturating count of RUN cycles with nothing for decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_count <= '0;
        end else if (state == RUN && !instr_valid && !redirect_valid
                     && starve_count != 32'hFFFF_FFFF) begin
            starve_count <= starve_count + 32'd1;
        end
    end
`endif

endmodule
